// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-line instruction cache between the
// decoder fetch port and the memory controller.
// Ports:
//   clk_in, rst_in (async, active-low), rdy_in (global stall when low)
//   clear      : pipeline flush, abandons the current fetch
//   if_enable, if_addr -> inst_ready (pulse), inst
//   mem_req, mem_addr  -> mem_done (pulse), mem_data
module icache #(
  parameter int IDX_WIDTH = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic        if_enable,
  input  logic [31:0] if_addr,
  output logic        inst_ready,
  output logic [31:0] inst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data
);

  localparam int LINES = 1 << IDX_WIDTH;
  localparam int TAG_W = 30 - IDX_WIDTH;

  typedef enum logic {
    IDLE,
    MISS
  } state_t;

  state_t state;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem [LINES];
  logic [31:0]      data_mem [LINES];

  logic [IDX_WIDTH-1:0] idx;
  logic [TAG_W-1:0]     tag;
  logic                 hit;

  // mem_addr doubles as the latched request address for the refill.
  logic [IDX_WIDTH-1:0] fill_idx;
  logic [TAG_W-1:0]     fill_tag;
  logic                 fill_we;

  assign idx = if_addr[IDX_WIDTH+1:2];
  assign tag = if_addr[31:IDX_WIDTH+2];
  assign hit = valid[idx] && (tag_mem[idx] == tag);

  assign fill_idx = mem_addr[IDX_WIDTH+1:2];
  assign fill_tag = mem_addr[31:IDX_WIDTH+2];

  // A refill lands even when clear arrives with mem_done: the data
  // is still correct for mem_addr.
  assign fill_we = rdy_in && (state == MISS) && mem_done;

  always_ff @(posedge clk_in) begin
    if (fill_we) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= mem_data;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state      <= IDLE;
      valid      <= '0;
      inst_ready <= 1'b0;
      inst       <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
    end else if (rdy_in) begin
      inst_ready <= 1'b0;
      if (fill_we) begin
        valid[fill_idx] <= 1'b1;
      end
      if (clear) begin
        state   <= IDLE;
        mem_req <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (if_enable) begin
              if (hit) begin
                inst       <= data_mem[idx];
                inst_ready <= 1'b1;
              end else begin
                mem_req  <= 1'b1;
                mem_addr <= if_addr & ~32'h3;
                state    <= MISS;
              end
            end
          end
          MISS: begin
            if (mem_done) begin
              inst       <= mem_data;
              inst_ready <= 1'b1;
              mem_req    <= 1'b0;
              state      <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_icache.sv
// tb_icache: directed self-checking bench for icache.
// Hand-computed vectors cover hit, miss, eviction, clear, stall, reset.
module tb_icache;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        clear;
  logic        if_enable;
  logic [31:0] if_addr;
  logic        inst_ready;
  logic [31:0] inst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_data;

  int n_chk;
  int n_err;

  icache #(.IDX_WIDTH(4)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .clear     (clear),
    .if_enable (if_enable),
    .if_addr   (if_addr),
    .inst_ready(inst_ready),
    .inst      (inst),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_done  (mem_done),
    .mem_data  (mem_data)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string t, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", t, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Issue one fetch, sampled on the next edge.
  task automatic fetch(input logic [31:0] a);
    if_enable = 1'b1;
    if_addr   = a;
    tick();
    if_enable = 1'b0;
  endtask

  // Deliver one memory word, sampled on the next edge.
  task automatic deliver(input logic [31:0] d);
    mem_done = 1'b1;
    mem_data = d;
    tick();
    mem_done = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_in = 1'b0;
    rdy_in = 1'b1;
    clear = 1'b0;
    if_enable = 1'b0;
    if_addr = '0;
    mem_done = 1'b0;
    mem_data = '0;
    #3;
    chk("rst_ready", 32'(inst_ready), 0);
    chk("rst_inst", inst, 0);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_maddr", mem_addr, 0);
    tick();
    rst_in = 1'b1;
    tick();

    // cold miss on 0x0
    fetch(32'h0);
    chk("m0_req", 32'(mem_req), 1);
    chk("m0_maddr", mem_addr, 32'h0);
    chk("m0_nordy", 32'(inst_ready), 0);
    deliver(32'h0000_0513);
    chk("m0_ready", 32'(inst_ready), 1);
    chk("m0_inst", inst, 32'h0000_0513);
    chk("m0_reqlo", 32'(mem_req), 0);
    tick();
    chk("m0_pulse", 32'(inst_ready), 0);

    // hit on 0x0, then back-to-back hit
    if_enable = 1'b1;
    if_addr = 32'h0;
    tick();
    chk("h0_ready", 32'(inst_ready), 1);
    chk("h0_inst", inst, 32'h0000_0513);
    chk("h0_req", 32'(mem_req), 0);
    if_addr = 32'h3;
    tick();
    if_enable = 1'b0;
    chk("h0b_ready", 32'(inst_ready), 1);
    chk("h0b_inst", inst, 32'h0000_0513);
    tick();
    chk("h0_idle", 32'(inst_ready), 0);

    // conflict: 0x40 shares index 0
    fetch(32'h40);
    chk("m40_req", 32'(mem_req), 1);
    chk("m40_maddr", mem_addr, 32'h40);
    tick();
    chk("m40_hold", 32'(mem_req), 1);
    deliver(32'h00A0_0093);
    chk("m40_inst", inst, 32'h00A0_0093);
    chk("m40_ready", 32'(inst_ready), 1);
    fetch(32'h0);
    chk("evict_req", 32'(mem_req), 1);
    chk("evict_rdy", 32'(inst_ready), 0);
    deliver(32'h0000_0513);
    chk("evict_inst", inst, 32'h0000_0513);

    // clear two cycles into a miss on 0x100
    fetch(32'h100);
    chk("m100_req", 32'(mem_req), 1);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_req", 32'(mem_req), 0);
    chk("clr_rdy", 32'(inst_ready), 0);
    deliver(32'hDEAD_BEEF);
    chk("stray_rdy", 32'(inst_ready), 0);
    chk("stray_req", 32'(mem_req), 0);
    fetch(32'h100);
    chk("m100b_req", 32'(mem_req), 1);
    chk("m100b_rdy", 32'(inst_ready), 0);

    // stall for 3 cycles with a mem_done pulse inside
    rdy_in = 1'b0;
    deliver(32'h1111_1111);
    tick();
    tick();
    chk("stall_req", 32'(mem_req), 1);
    chk("stall_rdy", 32'(inst_ready), 0);
    rdy_in = 1'b1;
    tick();
    chk("unstall_req", 32'(mem_req), 1);
    deliver(32'h0010_0113);
    chk("m100_ready", 32'(inst_ready), 1);
    chk("m100_inst", inst, 32'h0010_0113);
    fetch(32'h100);
    chk("h100_ready", 32'(inst_ready), 1);
    chk("h100_inst", inst, 32'h0010_0113);

    // clear together with mem_done: line written, no inst_ready
    fetch(32'h200);
    chk("m200_req", 32'(mem_req), 1);
    clear = 1'b1;
    deliver(32'h0020_0193);
    clear = 1'b0;
    chk("cd_rdy", 32'(inst_ready), 0);
    chk("cd_req", 32'(mem_req), 0);
    fetch(32'h200);
    chk("h200_ready", 32'(inst_ready), 1);
    chk("h200_inst", inst, 32'h0020_0193);
    chk("h200_req", 32'(mem_req), 0);

    // async reset mid-miss
    fetch(32'h4);
    deliver(32'h0030_0213);
    chk("m4_inst", inst, 32'h0030_0213);
    fetch(32'h8);
    chk("m8_req", 32'(mem_req), 1);
    #2;
    rst_in = 1'b0;
    #1;
    chk("arst_req", 32'(mem_req), 0);
    chk("arst_rdy", 32'(inst_ready), 0);
    chk("arst_maddr", mem_addr, 0);
    tick();
    rst_in = 1'b1;
    tick();
    fetch(32'h4);
    chk("post_req", 32'(mem_req), 1);
    chk("post_rdy", 32'(inst_ready), 0);
    deliver(32'h0030_0213);
    fetch(32'h100);
    chk("post100_req", 32'(mem_req), 1);
    deliver(32'h0010_0113);
    chk("post100_inst", inst, 32'h0010_0113);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
